// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the pmem line responder: FSM states, operation kind,
// line-offset width and the latency counter type.
package pmem_line_responder_pkg;

  localparam int unsigned PMEM_OFFSET_BITS = 5;
  localparam int unsigned PMEM_ADDR_BITS   = 32;
  localparam int unsigned PMEM_CNT_BITS    = 8;

  typedef logic [PMEM_CNT_BITS-1:0] pmem_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RECOVER
  } pmem_resp_states;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_t;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port cacheline storage, 2**IDX_BITS lines of LINE_BITS.
// Ports: clk, reset (sync, active-high, clears only the read register),
//        we/re (write/read enables), idx (line index), wdata (line in),
//        rdata (registered line out, holds between reads).
module pmem_line_array #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_BITS-1:0]  idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  logic [LINE_BITS-1:0] mem [DEPTH];

  // Storage is never cleared; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical-memory responder for 256-bit cacheline traffic.
// Ports: clk, reset (sync, active-high), pmem_read/pmem_write (requests held
//        until pmem_resp), pmem_address (byte address, index from [5 +: IDX_BITS]),
//        pmem_wdata, pmem_rdata (registered, updated only by reads),
//        pmem_resp (one-cycle strobe), proto_err (sticky protocol flag).
// Build option: define PMEM_PROTOCOL_CHECK_EN to enable the protocol checker;
//        otherwise proto_err is tied low.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_BITS     = 256,
  parameter int unsigned IDX_BITS      = 4,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pmem_read,
  input  logic                      pmem_write,
  input  logic [PMEM_ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]      pmem_wdata,
  output logic [LINE_BITS-1:0]      pmem_rdata,
  output logic                      pmem_resp,
  output logic                      proto_err
);

  localparam pmem_cnt_t RD_CNT_INIT = pmem_cnt_t'(READ_LATENCY - 1);
  localparam pmem_cnt_t WR_CNT_INIT = pmem_cnt_t'(WRITE_LATENCY - 1);
  localparam bit        RD_DIRECT   = (READ_LATENCY == 1);
  localparam bit        WR_DIRECT   = (WRITE_LATENCY == 1);

  pmem_resp_states      state, next_state;
  pmem_cnt_t            cnt_q, cnt_d;
  pmem_op_t             op_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic                 resp_q;

  logic [IDX_BITS-1:0]  req_idx_c;
  logic                 accept_c;
  pmem_op_t             op_in_c;
  logic                 arr_we_c, arr_re_c;
  logic [IDX_BITS-1:0]  arr_idx_c;
  logic                 addr_unused;

  assign req_idx_c   = pmem_address[PMEM_OFFSET_BITS +: IDX_BITS];
  assign accept_c    = (state == IDLE) && (pmem_read || pmem_write);
  assign op_in_c     = pmem_write ? OP_WRITE : OP_READ;
  assign addr_unused = ^{pmem_address[PMEM_ADDR_BITS-1:PMEM_OFFSET_BITS+IDX_BITS],
                         pmem_address[PMEM_OFFSET_BITS-1:0]};

  // Next-state and latency counter.
  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    case (state)
      IDLE: begin
        if (pmem_write) begin
          cnt_d      = WR_CNT_INIT;
          next_state = WR_DIRECT ? RESP : BUSY;
        end else if (pmem_read) begin
          cnt_d      = RD_CNT_INIT;
          next_state = RD_DIRECT ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= pmem_cnt_t'(1)) begin
          next_state = RESP;
        end else begin
          cnt_d = cnt_q - pmem_cnt_t'(1);
        end
      end
      RESP:    next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, counter and the registered response strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      resp_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt_q  <= cnt_d;
      resp_q <= (next_state == RESP);
    end
  end

  // Request latches, captured once at acceptance.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      op_q    <= op_in_c;
      idx_q   <= req_idx_c;
      wdata_q <= pmem_wdata;
    end
  end

  // In IDLE the live index feeds the array so a latency-1 read lands in RESP.
  always_comb begin
    arr_idx_c = (state == IDLE) ? req_idx_c : idx_q;
    arr_we_c  = (state == RESP) && (op_q == OP_WRITE) && !reset;
    arr_re_c  = (next_state == RESP) && !reset &&
                (((state == IDLE) && (op_in_c == OP_READ)) ||
                 ((state != IDLE) && (op_q == OP_READ)));
  end

  pmem_line_array #(
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we_c),
    .re    (arr_re_c),
    .idx   (arr_idx_c),
    .wdata (wdata_q),
    .rdata (pmem_rdata)
  );

  assign pmem_resp = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam int unsigned TAG_BITS = PMEM_ADDR_BITS - PMEM_OFFSET_BITS;

  logic [TAG_BITS-1:0] line_q;
  logic                both_c, drop_c, chg_c;
  logic                err_q;

  always_ff @(posedge clk) begin
    if (accept_c) begin
      line_q <= pmem_address[PMEM_ADDR_BITS-1:PMEM_OFFSET_BITS];
    end
  end

  // Violation detect: dual request at acceptance, or any request drift while busy.
  always_comb begin
    both_c = 1'b0;
    drop_c = 1'b0;
    chg_c  = 1'b0;
    if (state == IDLE) begin
      both_c = pmem_read && pmem_write;
    end
    if (state == BUSY) begin
      drop_c = (op_q == OP_WRITE) ? !pmem_write : !pmem_read;
      chg_c  = (line_q != pmem_address[PMEM_ADDR_BITS-1:PMEM_OFFSET_BITS]) ||
               ((op_q == OP_WRITE) ? pmem_read : pmem_write);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (both_c || drop_c || chg_c) begin
      err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      if (both_c) $error("pmem protocol: read and write both high at acceptance");
      if (drop_c) $error("pmem protocol: request dropped while busy");
      if (chg_c)  $error("pmem protocol: address or request type changed while busy");
    end
  end
`endif

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: directed requests push expected
// responses; a negedge monitor pops and checks each pmem_resp.
module tb_pmem_line_responder;

  localparam int unsigned LB = 256;
  localparam int unsigned RL = 4;
  localparam int unsigned WL = 6;
`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pmem_read, pmem_write;
  logic [31:0]   pmem_address;
  logic [LB-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp, proto_err;

  logic          r1_read, r1_write;
  logic [31:0]   r1_address;
  logic [LB-1:0] r1_wdata, r1_rdata;
  logic          r1_resp, r1_err;

  always #5 clk = ~clk;

  pmem_line_responder #(
    .LINE_BITS(LB), .IDX_BITS(4), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) u_dut (
    .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .proto_err(proto_err)
  );

  pmem_line_responder #(
    .LINE_BITS(LB), .IDX_BITS(4), .READ_LATENCY(1), .WRITE_LATENCY(1)
  ) u_dut_l1 (
    .clk(clk), .reset(reset), .pmem_read(r1_read), .pmem_write(r1_write),
    .pmem_address(r1_address), .pmem_wdata(r1_wdata), .pmem_rdata(r1_rdata),
    .pmem_resp(r1_resp), .proto_err(r1_err)
  );

  typedef struct {
    int            exp_cyc;
    logic [LB-1:0] exp_rd;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            resp_cyc = -10;
  logic [LB-1:0] last_rd = '0;
  bit            err_exp = 1'b0;

  localparam logic [LB-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LB-1:0] PAT_12 = {16{16'h1234}};
  localparam logic [LB-1:0] PAT_DE = {8{32'hDEADBEEF}};
  localparam logic [LB-1:0] PAT_C3 = {32{8'hC3}};
  localparam logic [LB-1:0] PAT_77 = {32{8'h77}};
  localparam logic [LB-1:0] PAT_5A = {32{8'h5A}};
  localparam logic [LB-1:0] PAT_11 = {32{8'h11}};
  localparam logic [LB-1:0] PAT_EE = {32{8'hEE}};
  localparam logic [LB-1:0] PAT_5C = {32{8'h5C}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pmem_resp) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_resp: resp at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_lat"}, LB'(cyc), LB'(e.exp_cyc));
        check({e.name, "_rdata"}, pmem_rdata, e.exp_rd);
        check({e.name, "_perr"}, LB'(proto_err), LB'(err_exp));
      end
    end
  end

  // Issue one request (called at a negedge) and hold it until resp.
  task automatic issue(input string nm, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [LB-1:0] wd,
                       input logic [LB-1:0] exp_data, input bit linger,
                       input bit chg_en, input logic [31:0] chg_addr);
    int            acc;
    int            n;
    logic [LB-1:0] e;
    bit            got;
    acc = (cyc > resp_cyc + 2) ? cyc : resp_cyc + 2;
    n   = wr ? int'(WL) : int'(RL);
    if (wr) begin
      e = last_rd;
    end else begin
      e       = exp_data;
      last_rd = exp_data;
    end
    if (CHK && rd && wr) err_exp = 1'b1;
    if (CHK && chg_en) err_exp = 1'b1;
    sb.push_back('{acc + n, e, nm});
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (chg_en && k == 1) pmem_address = chg_addr;
      if (pmem_resp) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no resp within 300 cycles, required one", nm);
      sb.delete();
    end
    resp_cyc = cyc;
    if (linger) @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    r1_read      = 1'b0;
    r1_write     = 1'b0;
    r1_address   = '0;
    r1_wdata     = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", LB'(pmem_resp), '0);
    check("rst_rdata", pmem_rdata, '0);
    check("rst_perr", LB'(proto_err), '0);
    reset = 1'b0;
    @(negedge clk);

    // Preload, then read back with full latency.
    issue("wr_a5", 0, 1, 32'h40, PAT_A5, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("rd_a5", 1, 0, 32'h40, '0, PAT_A5, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Write then read raised in RECOVER.
    issue("wr_1234", 0, 1, 32'h60, PAT_12, '0, 0, 0, '0);
    @(negedge clk);
    issue("rd_1234", 1, 0, 32'h60, '0, PAT_12, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Eviction sequence: read held through RECOVER, write raised right after.
    issue("wr_dead", 0, 1, 32'h100, PAT_DE, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("rd_dead", 1, 0, 32'h100, '0, PAT_DE, 1, 0, '0);
    issue("wr_evict", 0, 1, 32'h2E0, PAT_C3, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("rd_alias_e0", 1, 0, 32'h0E0, '0, PAT_C3, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("wr_200", 0, 1, 32'h200, PAT_77, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("rd_alias_000", 1, 0, 32'h01F, '0, PAT_77, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Simultaneous read+write acts as a write.
    issue("rdwr_both", 1, 1, 32'h20, PAT_5A, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    issue("rd_after_both", 1, 0, 32'h20, '0, PAT_5A, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Reset during BUSY cycle 3 of a write discards it.
    issue("wr_pre80", 0, 1, 32'h80, PAT_11, '0, 0, 0, '0);
    repeat (2) @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 32'h80;
    pmem_wdata   = PAT_EE;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    pmem_write = 1'b0;
    last_rd    = '0;
    err_exp    = 1'b0;
    resp_cyc   = -10;
    check("midrst_resp", LB'(pmem_resp), '0);
    check("midrst_rdata", pmem_rdata, '0);
    check("midrst_perr", LB'(proto_err), '0);
    issue("rd_after_rst", 1, 0, 32'h80, '0, PAT_11, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Address changed mid-BUSY: the latched index is used.
    issue("rd_addr_chg", 1, 0, 32'h40, '0, PAT_A5, 0, 1, 32'h60);
    repeat (4) @(negedge clk);
    check("sb_drained", LB'(sb.size()), '0);

    // Latency-1 instance: resp one cycle after acceptance.
    r1_write   = 1'b1;
    r1_address = 32'h40;
    r1_wdata   = PAT_5C;
    @(negedge clk);
    check("l1_wr_resp", LB'(r1_resp), LB'(1));
    r1_write = 1'b0;
    @(negedge clk);
    check("l1_recover_resp", LB'(r1_resp), '0);
    @(negedge clk);
    r1_read = 1'b1;
    @(negedge clk);
    check("l1_rd_resp", LB'(r1_resp), LB'(1));
    check("l1_rd_data", r1_rdata, PAT_5C);
    r1_read = 1'b0;
    @(negedge clk);
    check("l1_rd_single", LB'(r1_resp), '0);
    check("l1_perr", LB'(r1_err), '0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
